fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: tracks fetch_pc, issues word requests, and queues ordered
// responses in a prefetch FIFO. Optional macro FETCH_NOP_FILL_EN drives a NOP on inst_o when idle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_sel_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // Room for FIFO_DEPTH outstanding plus FIFO_DEPTH discards, with headroom.
  localparam int CW = $clog2(FIFO_DEPTH) + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] occ;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   last_pc;
  logic [31:0]   last_inst;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];

  logic          grant;
  logic          resp_live;
  logic          resp_drop;
  logic          resp_any;
  logic          push;
  logic          pop;
  logic [31:0]   resp_pc;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;
  logic          unused_tgt_bits;

  assign unused_tgt_bits = ^target_i[1:0];

  // A slot is reserved per request, so requests stop once FIFO plus live requests fill it.
  assign imem_req_o  = !rst && !pc_sel_i && ((occ + outstanding) < DEPTH_C);
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;

  // Responses with nothing live outstanding are leftovers from before a reset.
  assign resp_drop = imem_rvalid_i && (discard_cnt != '0);
  assign resp_live = imem_rvalid_i && (discard_cnt == '0) && (outstanding != '0);
  assign resp_any  = imem_rvalid_i && ((discard_cnt != '0) || (outstanding != '0));
  assign push      = resp_live && !pc_sel_i && !rst;

  // Live requests are consecutive words ending just below fetch_pc; the oldest answers first.
  assign resp_pc   = fetch_pc - (32'(outstanding) << 2);

  assign head_pc      = fifo_pc[rd_ptr];
  assign head_inst    = fifo_inst[rd_ptr];
  assign inst_valid_o = !rst && (occ != '0);
  assign pop          = inst_valid_o && inst_ready_i && !pc_sel_i;

  assign pc_o = rst ? RESET_PC : (inst_valid_o ? head_pc : last_pc);

`ifdef FETCH_NOP_FILL_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
  assign inst_o = inst_valid_o ? head_inst : NOP;
`else
  assign inst_o = inst_valid_o ? head_inst : (rst ? 32'h0 : last_inst);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      occ         <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      last_pc     <= RESET_PC;
      last_inst   <= 32'h0;
    end else if (pc_sel_i) begin
      // Redirect: every live request becomes a discard, minus one answered this cycle.
      fetch_pc    <= {target_i[31:2], 2'b00};
      occ         <= '0;
      outstanding <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      discard_cnt <= discard_cnt + outstanding - CW'(resp_any);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(grant) - CW'(resp_live);
      if (resp_drop) begin
        discard_cnt <= discard_cnt - 1'b1;
      end
      occ <= occ + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_pc   <= head_pc;
        last_inst <= head_inst;
      end
    end
  end

  // FIFO storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= resp_pc;
      fifo_inst[wr_ptr] <= imem_rdata_i;
    end
  end

endmodule
